// File: rtl/calc_key_pkg.sv
// Shared key codes, widths and issue-FSM states for the calculator key sequencer.
package calc_key_pkg;

   localparam int KEY_W    = 5;
   localparam int NUM_KEYS = 18;

   localparam logic [KEY_W-1:0] KEY_D0    = 5'd0;
   localparam logic [KEY_W-1:0] KEY_D1    = 5'd1;
   localparam logic [KEY_W-1:0] KEY_D2    = 5'd2;
   localparam logic [KEY_W-1:0] KEY_D3    = 5'd3;
   localparam logic [KEY_W-1:0] KEY_D4    = 5'd4;
   localparam logic [KEY_W-1:0] KEY_D5    = 5'd5;
   localparam logic [KEY_W-1:0] KEY_D6    = 5'd6;
   localparam logic [KEY_W-1:0] KEY_D7    = 5'd7;
   localparam logic [KEY_W-1:0] KEY_D8    = 5'd8;
   localparam logic [KEY_W-1:0] KEY_D9    = 5'd9;
   localparam logic [KEY_W-1:0] KEY_PLUS  = 5'd10;
   localparam logic [KEY_W-1:0] KEY_MINUS = 5'd11;
   localparam logic [KEY_W-1:0] KEY_MUL   = 5'd12;
   localparam logic [KEY_W-1:0] KEY_DIV   = 5'd13;
   localparam logic [KEY_W-1:0] KEY_SQR   = 5'd14;
   localparam logic [KEY_W-1:0] KEY_EQUAL = 5'd15;
   localparam logic [KEY_W-1:0] KEY_CE    = 5'd16;
   localparam logic [KEY_W-1:0] KEY_AC    = 5'd17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [KEY_W-1:0] code);
      return {{(NUM_KEYS-1){1'b0}}, 1'b1} << code;
   endfunction

endpackage

// File: rtl/calc_key_debounce.sv
// One key: 2-flop synchronizer followed by a stable-count debouncer.
module calc_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic key_i,
   output logic level_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle that agrees with the current level restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], key_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/calc_key_sequencer.sv
// Debounce, arbitrate, queue and issue calculator key commands as spaced one-cycle pulses.
// Optional ce long-press to ac conversion is enabled by defining CALC_LONG_CE_AC_EN.
module calc_key_sequencer
   import calc_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 20000,
   parameter int FIFO_DEPTH        = 4,
   parameter int GAP_CYCLES        = 2,
   parameter int LONG_PRESS_CYCLES = 2000000
) (
   input  logic                             sys_clk,
   input  logic                             rst_n,
   input  logic [NUM_KEYS-1:0]              key_raw,
   output logic [9:0]                       input_decimal,
   output logic                             plus,
   output logic                             minus,
   output logic                             mul,
   output logic                             div,
   output logic                             square,
   output logic                             equal,
   output logic                             ce,
   output logic                             ac,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             drop_err,
   output logic                             busy
);

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   logic [NUM_KEYS-1:0] level, level_prev_q, press, ev;

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_db
      calc_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .sys_clk (sys_clk),
         .rst_n   (rst_n),
         .key_i   (key_raw[gi]),
         .level_o (level[gi])
      );
   end

   assign press = level & ~level_prev_q;

`ifdef CALC_LONG_CE_AC_EN
   localparam int LP_W = $clog2(LONG_PRESS_CYCLES);

   logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
   logic            lp_done_q, lp_done_d, lp_fire;

   // One ac per continuous ce hold; re-armed only by releasing ce.
   always_comb begin
      lp_cnt_d  = lp_cnt_q;
      lp_done_d = lp_done_q;
      lp_fire   = 1'b0;
      if (!level[KEY_CE]) begin
         lp_cnt_d  = '0;
         lp_done_d = 1'b0;
      end else if (!lp_done_q) begin
         if (lp_cnt_q == LP_W'(LONG_PRESS_CYCLES - 1)) begin
            lp_fire   = 1'b1;
            lp_done_d = 1'b1;
         end else begin
            lp_cnt_d = lp_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         lp_cnt_q  <= '0;
         lp_done_q <= 1'b0;
      end else begin
         lp_cnt_q  <= lp_cnt_d;
         lp_done_q <= lp_done_d;
      end
   end

   assign ev = press | (lp_fire ? key_onehot(KEY_AC) : '0);
`else
   logic unused_long_press_cfg;
   assign unused_long_press_cfg = (LONG_PRESS_CYCLES > 0);
   assign ev = press;
`endif

   // Key codes are ordered by priority, so the highest set bit wins.
   logic             win_valid, multi_ev, ac_event, push_req, push, pop, full, drop;
   logic [KEY_W-1:0] win_code;

   always_comb begin
      win_valid = 1'b0;
      win_code  = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (ev[i]) begin
            win_valid = 1'b1;
            win_code  = KEY_W'(i);
         end
      end
   end

   assign multi_ev = |(ev & (ev - key_onehot(KEY_D0)));
   assign ac_event = win_valid && (win_code == KEY_AC);
   assign push_req = win_valid && !ac_event;
   assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign push     = push_req && (!full || pop);
   assign drop     = multi_ev || (push_req && !push);

   logic [KEY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] count_q;

   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= win_code;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         level_prev_q <= '0;
      end else begin
         level_prev_q <= level;
         if (ac_event) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_q + LVL_W'(push) - LVL_W'(pop);
         end
      end
   end

   state_t              state_q, state_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [NUM_KEYS-1:0] out_q, out_d;
   logic                ac_pend_q, ac_pend_d, drop_q, drop_d, issue_ac, fifo_ne;

   assign fifo_ne = (count_q != '0);

   // A pending ac may leave GAP early; queued keys wait for the full gap.
   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      out_d    = '0;
      pop      = 1'b0;
      issue_ac = 1'b0;
      case (state_q)
         IDLE: begin
            if (ac_pend_q) begin
               state_d  = ISSUE;
               out_d    = key_onehot(KEY_AC);
               issue_ac = 1'b1;
            end else if (fifo_ne) begin
               state_d = ISSUE;
               out_d   = key_onehot(mem[rd_ptr_q]);
               pop     = 1'b1;
            end
         end
         ISSUE: begin
            state_d = GAP;
            gap_d   = '0;
         end
         GAP: begin
            if (ac_pend_q) begin
               state_d  = ISSUE;
               out_d    = key_onehot(KEY_AC);
               issue_ac = 1'b1;
            end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               if (fifo_ne) begin
                  state_d = ISSUE;
                  out_d   = key_onehot(mem[rd_ptr_q]);
                  pop     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      ac_pend_d = ac_event || (ac_pend_q && !issue_ac);
      drop_d    = drop || (drop_q && !issue_ac);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gap_q     <= '0;
         out_q     <= '0;
         ac_pend_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         out_q     <= out_d;
         ac_pend_q <= ac_pend_d;
         drop_q    <= drop_d;
      end
   end

   assign input_decimal = out_q[9:0];
   assign plus          = out_q[KEY_PLUS];
   assign minus         = out_q[KEY_MINUS];
   assign mul           = out_q[KEY_MUL];
   assign div           = out_q[KEY_DIV];
   assign square        = out_q[KEY_SQR];
   assign equal         = out_q[KEY_EQUAL];
   assign ce            = out_q[KEY_CE];
   assign ac            = out_q[KEY_AC];
   assign fifo_level    = count_q;
   assign drop_err      = drop_q;
   assign busy          = (state_q != IDLE) || fifo_ne;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scenario-driven self-checking bench for calc_key_sequencer with a queue-based reference of issued commands.
module tb_calc_key_sequencer;

   localparam int DEB  = 4;
   localparam int DEP  = 4;
   localparam int GAPC = 2;
   localparam int LONG = 16;

   logic        sys_clk;
   logic        rst_n;
   logic [17:0] key_raw;
   logic [9:0]  input_decimal;
   logic        plus, minus, mul, div, square, equal, ce, ac;
   logic [2:0]  fifo_level;
   logic        drop_err, busy;

   calc_key_sequencer #(
      .DEBOUNCE_CYCLES   (DEB),
      .FIFO_DEPTH        (DEP),
      .GAP_CYCLES        (GAPC),
      .LONG_PRESS_CYCLES (LONG)
   ) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .key_raw       (key_raw),
      .input_decimal (input_decimal),
      .plus          (plus),
      .minus         (minus),
      .mul           (mul),
      .div           (div),
      .square        (square),
      .equal         (equal),
      .ce            (ce),
      .ac            (ac),
      .fifo_level    (fifo_level),
      .drop_err      (drop_err),
      .busy          (busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int multi_cnt = 0;

   typedef struct {
      int   code;
      int   cyc;
      logic derr;
   } pulse_t;

   pulse_t pulses[$];

   logic [17:0] obs;
   assign obs = {ac, ce, equal, square, div, mul, minus, plus, input_decimal};

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc++;

   // Record every visible command pulse with its cycle and the drop flag alongside.
   always @(negedge sys_clk) begin
      if (obs != '0) begin
         int c;
         c = -1;
         for (int i = 0; i < 18; i++) if (obs[i]) c = i;
         if ($countones(obs) != 1) multi_cnt++;
         pulses.push_back('{c, cyc, drop_err});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic check_list(input string name, input int exp[$]);
      checks++;
      if (pulses.size() != exp.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d pulses expected %0d", name, pulses.size(), exp.size());
      end
      foreach (exp[i]) begin
         int got;
         got = (i < pulses.size()) ? pulses[i].code : -1;
         checks++;
         if (got != exp[i]) begin
            errors++;
            $display("FAIL %s[%0d]: got code %0d expected %0d", name, i, got, exp[i]);
         end
         if (i > 0 && i < pulses.size()) begin
            checks++;
            if (pulses[i].cyc - pulses[i-1].cyc < 1 + GAPC) begin
               errors++;
               $display("FAIL %s_pitch[%0d]: got %0d expected >=%0d", name, i,
                        pulses[i].cyc - pulses[i-1].cyc, 1 + GAPC);
            end
         end
      end
      $display("%s: %0d pulses observed, %0d expected", name, pulses.size(), exp.size());
   endtask

   task automatic test_reset;
      int exp[$];
      rst_n = 1'b0;
      key_raw = '0;
      key_raw[9] = 1'b1;
      tick(3);
      checks++;
      if (obs !== 18'h0 || fifo_level !== 3'd0 || busy !== 1'b0 || drop_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got obs=%h lvl=%0d busy=%b derr=%b expected all 0",
                  obs, fifo_level, busy, drop_err);
      end
      pulses.delete();
      rst_n = 1'b1;
      tick(12);
      key_raw[9] = 1'b0;
      tick(15);
      exp = '{9};
      check_list("reset_held_key", exp);
   endtask

   task automatic test_bounce;
      int exp[$];
      pulses.delete();
      for (int i = 0; i < 10; i++) begin
         key_raw[7] = ~key_raw[7];
         tick(1);
      end
      key_raw[7] = 1'b1;
      tick(6);
      key_raw[7] = 1'b0;
      tick(15);
      exp = '{7};
      check_list("bounce", exp);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bounce_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_sequence;
      int exp[$];
      exp = '{1, 2, 3, 10};
      pulses.delete();
      foreach (exp[i]) begin
         key_raw[exp[i]] = 1'b1;
         tick(6);
         key_raw[exp[i]] = 1'b0;
         tick(2);
      end
      tick(20);
      check_list("sequence", exp);
   endtask

   task automatic test_random;
      int exp[$];
      pulses.delete();
      for (int n = 0; n < 12; n++) begin
         int k, nb;
         k = $urandom_range(0, 15);
         exp.push_back(k);
         nb = $urandom_range(0, 3);
         for (int b = 0; b < nb; b++) begin
            key_raw[k] = 1'b1;
            tick(1);
            key_raw[k] = 1'b0;
            tick(1);
         end
         key_raw[k] = 1'b1;
         tick($urandom_range(5, 9));
         key_raw[k] = 1'b0;
         tick($urandom_range(6, 10));
      end
      tick(20);
      check_list("random", exp);
      checks++;
      if (drop_err !== 1'b0 || fifo_level !== 3'd0 || multi_cnt != 0) begin
         errors++;
         $display("FAIL random_tail: got derr=%b lvl=%0d multi=%0d expected 0 0 0",
                  drop_err, fifo_level, multi_cnt);
      end
   endtask

   task automatic test_fill_ac;
      int keys[7] = '{0, 1, 2, 4, 5, 6, 7};
      int max_lvl, prev_lvl, flush_prev, ac_idx;
      logic seen, flushed, derr_at_flush;
      pulses.delete();
      for (int i = 0; i < 7; i++) begin
         key_raw[keys[i]] = 1'b1;
         tick(1);
      end
      key_raw[17] = 1'b1;
      max_lvl = 0; prev_lvl = 0; flush_prev = 0;
      seen = 1'b0; flushed = 1'b0; derr_at_flush = 1'b0;
      for (int n = 0; n < 40 && !flushed; n++) begin
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
         if (fifo_level != 3'd0) seen = 1'b1;
         else if (seen) begin
            flushed = 1'b1;
            flush_prev = prev_lvl;
            derr_at_flush = drop_err;
         end
         prev_lvl = int'(fifo_level);
         tick(1);
      end
      checks++;
      if (max_lvl != DEP) begin
         errors++;
         $display("FAIL fill_max_level: got %0d expected %0d", max_lvl, DEP);
      end
      checks++;
      if (!flushed || flush_prev < 2) begin
         errors++;
         $display("FAIL fill_flush: got flushed=%b from level %0d expected drop to 0 from >=2",
                  flushed, flush_prev);
      end
      checks++;
      if (derr_at_flush !== 1'b1) begin
         errors++;
         $display("FAIL fill_drop_err: got %b expected 1", derr_at_flush);
      end
      tick(10);
      key_raw = '0;
      tick(30);
      ac_idx = -1;
      foreach (pulses[i]) if (ac_idx < 0 && pulses[i].code == 17) ac_idx = i;
      checks++;
      if (ac_idx < 1 || ac_idx != pulses.size() - 1) begin
         errors++;
         $display("FAIL fill_ac_last: got ac at %0d of %0d pulses expected last and >=1",
                  ac_idx, pulses.size());
      end
      for (int i = 0; i < ac_idx; i++) begin
         checks++;
         if (pulses[i].code != keys[i]) begin
            errors++;
            $display("FAIL fill_prefix[%0d]: got %0d expected %0d", i, pulses[i].code, keys[i]);
         end
      end
      if (ac_idx >= 0) begin
         checks++;
         if (pulses[ac_idx].derr !== 1'b0) begin
            errors++;
            $display("FAIL fill_ac_clears: got drop_err %b with ac expected 0", pulses[ac_idx].derr);
         end
      end
      $display("fill_ac: max level %0d, ac at pulse %0d of %0d", max_lvl, ac_idx, pulses.size());
   endtask

   task automatic test_collision;
      int exp[$];
      pulses.delete();
      key_raw[3]  = 1'b1;
      key_raw[11] = 1'b1;
      tick(6);
      key_raw = '0;
      tick(15);
      exp = '{11};
      check_list("collision", exp);
      checks++;
      if (drop_err !== 1'b1) begin
         errors++;
         $display("FAIL collision_drop_err: got %b expected 1", drop_err);
      end
   endtask

   task automatic test_reset_mid_issue;
      logic hit;
      hit = 1'b0;
      key_raw[5] = 1'b1;
      for (int n = 0; n < 30 && !hit; n++) begin
         tick(1);
         if (obs != '0) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_issue_wait: got no pulse within 30 cycles expected one");
      end
      rst_n = 1'b0;
      key_raw = '0;
      #1;
      checks++;
      if (obs !== 18'h0 || busy !== 1'b0 || drop_err !== 1'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL mid_issue_reset: got obs=%h busy=%b derr=%b lvl=%0d expected all 0",
                  obs, busy, drop_err, fifo_level);
      end
      tick(3);
      rst_n = 1'b1;
      pulses.delete();
      tick(50);
      checks++;
      if (pulses.size() != 0) begin
         errors++;
         $display("FAIL mid_issue_quiet: got %0d pulses expected 0", pulses.size());
      end
      $display("reset_mid_issue: %0d pulses after release", pulses.size());
   endtask

   task automatic test_long_ce;
      int exp[$];
      pulses.delete();
      key_raw[16] = 1'b1;
      tick(30);
      key_raw[16] = 1'b0;
      tick(30);
`ifdef CALC_LONG_CE_AC_EN
      exp = '{16, 17};
`else
      exp = '{16};
`endif
      check_list("long_ce", exp);
   endtask

   initial begin
      rst_n   = 1'b0;
      key_raw = '0;
      test_reset();
      test_bounce();
      test_sequence();
      test_random();
      test_fill_ac();
      test_collision();
      test_reset_mid_issue();
      test_long_ce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
